// File: rtl/convergence_monitor.sv
// Observes a chain of FEA nodes, tracks the largest per-step change and declares
// convergence (or timeout on a step budget), latching a node snapshot on either outcome.
module convergence_monitor #(
  parameter int unsigned N_NODES       = 4,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       valid,
  input  logic [N_NODES*WIDTH-1:0]   nodevals,
  input  logic [WIDTH-1:0]           tol,
  input  logic [31:0]                max_steps,
  input  logic [7:0]                 rd_idx,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       busy,
  output logic                       converged,
  output logic                       timeout,
  output logic [31:0]                step_count,
  output logic [WIDTH-1:0]           max_delta
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PRIME, TRACK, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q [N_NODES];
  logic [WIDTH-1:0] prev_d [N_NODES];
  logic [WIDTH-1:0] snap_q [N_NODES];
  logic [WIDTH-1:0] snap_d [N_NODES];
  logic [WIDTH-1:0] cur    [N_NODES];
  logic [WIDTH-1:0] delta  [N_NODES];
  logic [WIDTH-1:0] step_maxd;
  logic [SW-1:0]    stable_q, stable_d;
  logic [31:0]      step_q, step_d;
  logic [WIDTH-1:0] maxd_q, maxd_d;
  logic             conv_q, conv_d;
  logic             tout_q, tout_d;

  // Absolute change per node, computed on the larger-minus-smaller side so it never wraps.
  always_comb begin
    step_maxd = '0;
    for (int i = 0; i < int'(N_NODES); i++) begin
      cur[i]   = nodevals[i*WIDTH +: WIDTH];
      delta[i] = (cur[i] > prev_q[i]) ? (cur[i] - prev_q[i]) : (prev_q[i] - cur[i]);
      if (delta[i] > step_maxd) step_maxd = delta[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      stable_q <= '0;
      step_q   <= '0;
      maxd_q   <= '0;
      conv_q   <= 1'b0;
      tout_q   <= 1'b0;
      // NOTE: the snapshot and previous-sample arrays are cleared too, because rd_data must read 0 after reset.
      for (int i = 0; i < int'(N_NODES); i++) begin
        prev_q[i] <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q  <= state_d;
      prev_q   <= prev_d;
      snap_q   <= snap_d;
      stable_q <= stable_d;
      step_q   <= step_d;
      maxd_q   <= maxd_d;
      conv_q   <= conv_d;
      tout_q   <= tout_d;
    end
  end

  // Next-state logic; start takes priority in every state.
  always_comb begin
    // NOTE: every target holds by default so no path through this block can infer a latch.
    state_d  = state_q;
    prev_d   = prev_q;
    snap_d   = snap_q;
    stable_d = stable_q;
    step_d   = step_q;
    maxd_d   = maxd_q;
    conv_d   = conv_q;
    tout_d   = tout_q;
    if (start) begin
      state_d  = PRIME;
      stable_d = '0;
      step_d   = '0;
      maxd_d   = '0;
      conv_d   = 1'b0;
      tout_d   = 1'b0;
    end else if (valid) begin
      case (state_q)
        PRIME: begin
          prev_d  = cur;
          state_d = TRACK;
        end
        TRACK: begin
          prev_d   = cur;
          step_d   = step_q + 32'd1;
          maxd_d   = step_maxd;
          stable_d = (step_maxd <= tol) ? stable_q + SW'(1) : '0;
          // Convergence is tested first so it wins a tie with the step budget.
          if (stable_d == SW'(STABLE_CYCLES)) begin
            conv_d  = 1'b1;
            snap_d  = cur;
            state_d = DONE;
          end else if ((max_steps != 32'd0) && (step_d == max_steps)) begin
            tout_d  = 1'b1;
            snap_d  = cur;
            state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    busy    = (state_q == PRIME) || (state_q == TRACK);
    rd_data = '0;
    for (int i = 0; i < int'(N_NODES); i++) begin
      if (rd_idx == 8'(i)) rd_data = snap_q[i];
    end
  end

  assign converged  = conv_q;
  assign timeout    = tout_q;
  assign step_count = step_q;
  assign max_delta  = maxd_q;

endmodule

// File: tb/tb_convergence_monitor.sv
// Scoreboard bench for convergence_monitor: a run-level reference model predicts each
// run's outcome, and an end-of-run monitor compares it against what the design reports.
module tb_convergence_monitor;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SC = 4;

  logic           clk = 1'b0;
  logic           reset, start, valid;
  logic [N*W-1:0] nodevals;
  logic [W-1:0]   tol;
  logic [31:0]    max_steps;
  logic [7:0]     rd_idx;
  logic [W-1:0]   rd_data;
  logic           busy, converged, timeout;
  logic [31:0]    step_count;
  logic [W-1:0]   max_delta;

  convergence_monitor #(.N_NODES(N), .WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .nodevals(nodevals),
    .tol(tol), .max_steps(max_steps), .rd_idx(rd_idx), .rd_data(rd_data),
    .busy(busy), .converged(converged), .timeout(timeout),
    .step_count(step_count), .max_delta(max_delta)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        conv;
    logic        tout;
    logic [31:0] steps;
    logic [W-1:0] maxd;
    logic [W-1:0] rd;
    int          end_cyc;
    int          used;
  } exp_t;

  exp_t           exp_q[$];
  logic [N*W-1:0] samples[$];
  int             n_vec    = 0;
  int             n_err    = 0;
  int             done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [N*W-1:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Run-level model: walk the valid samples in order, applying the convergence rules directly.
  function automatic exp_t model(input logic [W-1:0] t, input logic [31:0] ms, input logic [7:0] idx);
    exp_t           e;
    logic [N*W-1:0] prev, now, snap;
    logic [W-1:0]   a, b, d, md;
    int             stable;
    e.conv = 1'b0; e.tout = 1'b0; e.steps = '0; e.maxd = '0; e.rd = '0;
    e.end_cyc = 0; e.used = 0;
    stable = 0;
    snap   = '0;
    prev   = samples[0];
    for (int k = 1; k < samples.size(); k++) begin
      now = samples[k];
      md  = '0;
      for (int i = 0; i < N; i++) begin
        a = now[i*W +: W];
        b = prev[i*W +: W];
        d = (a > b) ? a - b : b - a;
        if (d > md) md = d;
      end
      prev    = now;
      e.steps = e.steps + 1;
      e.maxd  = md;
      stable  = (md <= t) ? stable + 1 : 0;
      if (stable == SC) begin
        e.conv = 1'b1; snap = now; e.used = k + 1;
        break;
      end
      if (ms != 0 && e.steps == ms) begin
        e.tout = 1'b1; snap = now; e.used = k + 1;
        break;
      end
    end
    if (idx < N) e.rd = snap[idx*W +: W];
    return e;
  endfunction

  // gap_mode: 0 random idle cycles, 1 strict valid/idle alternation, 2 no gaps.
  task automatic run(input logic [W-1:0] t, input logic [31:0] ms, input logic [7:0] idx, input int gap_mode);
    exp_t e;
    int   target;
    int   k;
    e = model(t, ms, idx);
    if (e.used == 0) begin
      $display("note: generated sequence does not terminate, run skipped");
      return;
    end
    target    = done_cnt + 1;
    tol       = t;
    max_steps = ms;
    rd_idx    = idx;
    start     = 1'b1;
    valid     = 1'($urandom_range(0, 1));
    nodevals  = garbage();
    @(posedge clk); #1;
    start = 1'b0;
    valid = 1'b0;
    check("busy_after_start", busy, 1);
    check("steps_cleared", step_count, 0);
    check("outcome_cleared", {converged, timeout}, 0);
    for (int j = 0; j < e.used; j++) begin
      if (gap_mode == 1 && j > 0) begin
        valid = 1'b0; nodevals = garbage();
        @(posedge clk); #1;
      end else if (gap_mode == 0) begin
        while ($urandom_range(0, 3) == 0) begin
          valid = 1'b0; nodevals = garbage();
          @(posedge clk); #1;
        end
      end
      valid    = 1'b1;
      nodevals = samples[j];
      if (j == e.used - 1) begin
        e.end_cyc = cyc + 1;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid    = 1'b0;
    nodevals = garbage();
    k = 0;
    while (done_cnt < target && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (done_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL run_end: no end of run seen, expected step_count %0d", e.steps);
      exp_q.delete();
    end
  endtask

  task automatic gen_random(output logic [W-1:0] t, output logic [31:0] ms);
    logic [W-1:0]   v [N];
    logic [N*W-1:0] s;
    int             r, settle, dd;
    int             ranges[4] = '{0, 5, 30, 500};
    samples.delete();
    t      = W'($urandom_range(0, 20));
    r      = ranges[$urandom_range(0, 3)];
    settle = $urandom_range(1, 30);
    ms     = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
    for (int i = 0; i < N; i++) v[i] = W'($urandom_range(100000, 32'hF000_0000));
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        for (int i = 0; i < N; i++) begin
          dd = (k < settle) ? $urandom_range(0, r) : $urandom_range(0, int'(t));
          v[i] = ($urandom_range(0, 1) == 1) ? v[i] + W'(dd) : v[i] - W'(dd);
        end
      end
      for (int i = 0; i < N; i++) s[i*W +: W] = v[i];
      samples.push_back(s);
    end
  endtask

  exp_t mon_e;
  logic busy_prev = 1'b0;

  // End-of-run monitor: a busy fall with an outcome flag is the design presenting a result.
  always @(negedge clk) begin
    if (busy_prev && !busy && (converged || timeout)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_end: run ended at step_count %0d with nothing expected", step_count);
      end else begin
        mon_e = exp_q.pop_front();
        check("converged", converged, mon_e.conv);
        check("timeout", timeout, mon_e.tout);
        check("step_count", step_count, mon_e.steps);
        check("max_delta", max_delta, mon_e.maxd);
        check("snapshot_rd_data", rd_data, mon_e.rd);
        check("end_cycle", cyc, mon_e.end_cyc);
      end
      done_cnt++;
    end
    busy_prev = busy;
  end

  logic [W-1:0]   rt;
  logic [31:0]    rms;
  logic [N*W-1:0] s;

  initial begin
    reset = 1'b1; start = 1'b0; valid = 1'b0; nodevals = '0;
    tol = '0; max_steps = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_converged", converged, 0);
    check("reset_timeout", timeout, 0);
    check("reset_step_count", step_count, 0);
    check("reset_max_delta", max_delta, 0);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 8'(i);
      #1;
      check("reset_rd_data", rd_data, 0);
    end
    @(posedge clk); #1;

    // Plain convergence: all nodes at 1000.
    samples.delete();
    repeat (5) samples.push_back({N{32'd1000}});
    run(32'd0, 32'd0, 8'd2, 2);
    check("conv_converged", converged, 1);
    check("conv_step_count", step_count, 4);
    check("conv_max_delta", max_delta, 0);
    check("conv_timeout", timeout, 0);
    check("conv_rd_idx2", rd_data, 1000);
    check("conv_busy_held_low", busy, 0);

    // Timeout while node0 falls by 10 each step; extra samples must never be consumed.
    samples.delete();
    for (int k = 0; k < 12; k++) begin
      s = {N{32'd500}};
      s[W-1:0] = 32'(3000 - 10 * k);
      samples.push_back(s);
    end
    run(32'd5, 32'd8, 8'd0, 2);
    check("tout_timeout", timeout, 1);
    check("tout_step_count", step_count, 8);
    check("tout_max_delta", max_delta, 10);
    check("tout_converged", converged, 0);
    check("tout_rd_idx0", rd_data, 2920);

    // Convergence and budget on the same step.
    samples.delete();
    repeat (5) samples.push_back({N{32'd7777}});
    run(32'd0, 32'd4, 8'd3, 2);
    check("tie_converged", converged, 1);
    check("tie_timeout", timeout, 0);
    check("tie_step_count", step_count, 4);

    // Alternating valid gaps.
    samples.delete();
    repeat (5) samples.push_back({N{32'd42}});
    run(32'd0, 32'd0, 8'd1, 1);
    check("gap_converged", converged, 1);
    check("gap_step_count", step_count, 4);

    // Random runs.
    for (int r = 0; r < 25; r++) begin
      gen_random(rt, rms);
      run(rt, rms, 8'($urandom_range(0, 7)), 0);
    end

    // Abort mid-run, then reset mid-run. Snapshot currently holds the last random run; reload a known one.
    samples.delete();
    repeat (5) samples.push_back({N{32'd42}});
    run(32'd0, 32'd0, 8'd0, 2);
    tol = '0; max_steps = '0; rd_idx = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; nodevals = {N{32'd55}};
      @(posedge clk); #1;
    end
    check("abort_pre_steps", step_count, 2);
    check("abort_pre_busy", busy, 1);
    start = 1'b1; valid = 1'b1; nodevals = {N{32'd55}};
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_steps_cleared", step_count, 0);
    check("abort_busy", busy, 1);
    check("abort_max_delta", max_delta, 0);
    valid = 1'b1; nodevals = {N{32'd99}};
    @(posedge clk); #1;
    check("abort_reprime_no_step", step_count, 0);
    @(posedge clk); #1;
    check("abort_first_step", step_count, 1);
    check("abort_first_delta", max_delta, 0);
    check("abort_snapshot_kept", rd_data, 42);
    reset = 1'b1; valid = 1'b1; nodevals = {N{32'd123}};
    @(posedge clk); #1;
    reset = 1'b0; valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_converged", converged, 0);
    check("rst_timeout", timeout, 0);
    check("rst_step_count", step_count, 0);
    check("rst_max_delta", max_delta, 0);
    check("rst_rd_idx0", rd_data, 0);
    rd_idx = 8'd7;
    #1;
    check("rst_rd_idx7", rd_data, 0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/convergence_monitor.md
# convergence_monitor

Downstream observer for a chain of `node` elements in the 1D FEA array. Samples every node value each cycle the chain is in RUN, tracks the largest per-node change between consecutive samples, and declares convergence once that change stays within a tolerance for a programmed number of consecutive steps. Declares timeout if a step budget runs out first. On either outcome it latches a snapshot of all node values for host readout.

## Interface
Parameters:
- `N_NODES`, 4: number of nodes observed.
- `WIDTH`, 32: node value width, unsigned.
- `STABLE_CYCLES`, 4: consecutive in-tolerance steps required for convergence (≥1).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin or restart a monitoring run.
- `valid`  in  1  node chain advanced this cycle (high while nodes are in RUN).
- `nodevals`  in  N_NODES*WIDTH  node values, flat bus; node i at bits [i*WIDTH +: WIDTH].
- `tol`  in  WIDTH  tolerance on absolute per-step change.
- `max_steps`  in  32  step budget; 0 means no limit.
- `rd_idx`  in  8  snapshot read index.
- `rd_data`  out  WIDTH  snapshot value of node `rd_idx`; 0 if `rd_idx` ≥ N_NODES.
- `busy`  out  1  run in progress (PRIME or TRACK).
- `converged`  out  1  run ended by convergence.
- `timeout`  out  1  run ended by step budget.
- `step_count`  out  32  tracked steps in the current or last run.
- `max_delta`  out  WIDTH  largest per-node |change| of the most recent step.

## Operation
- States: IDLE, PRIME, TRACK, DONE. Reset value is IDLE. At reset, all registered outputs, the snapshot, the previous-sample registers and the stable counter are 0.
- IDLE: `busy`=0. When `start`=1: clear `step_count`, the stable counter, `converged`, `timeout` and `max_delta`, then go to PRIME.
- PRIME: waits for `valid`. On a `valid` cycle, copies `nodevals` into the previous-sample registers and goes to TRACK. `step_count` is not incremented.
- TRACK, on each `valid` cycle:
  - delta_i = |nodevals_i − prev_i|. Compute unsigned, no wrap: when prev > new, delta = prev − new.
  - `max_delta` = max over i of delta_i.
  - prev is set to nodevals.
  - `step_count` increments by 1.
  - If `max_delta` ≤ `tol`, the stable counter increments. Otherwise it clears to 0.
- Exit from TRACK on the same edge, judged on the updated counts:
  - If stable counter = STABLE_CYCLES: `converged`=1, snapshot is set to the current `nodevals`, go to DONE.
  - Else if `max_steps`≠0 and `step_count` = `max_steps`: `timeout`=1, snapshot is set to the current `nodevals`, go to DONE.
  - If both conditions hold on the same step, convergence wins and `timeout` stays 0.
- `valid`=0 in PRIME or TRACK: all state holds. A gap does not reset the stable counter.
- DONE: `busy`=0. `converged`, `timeout`, `step_count`, `max_delta` and the snapshot hold until `start` or `reset`. `start` here behaves as it does in IDLE.
- `start` in PRIME or TRACK aborts the run. It clears state as in IDLE and re-enters PRIME. The snapshot is not modified.
- `reset` at any time overrides everything and forces IDLE with all outputs 0.
- `tol`, `max_steps` and `nodevals` are sampled live each cycle. The host keeps `tol` and `max_steps` stable during a run.
- `rd_data` is combinational from the snapshot registers and `rd_idx`.

## Timing
- All outputs except `rd_data` are registered.
- `busy` rises in the cycle after the edge that samples `start`.
- With `valid` held high from PRIME onward and every step in tolerance:
  - prime at edge e0, first tracked step at e1.
  - `converged` visible after edge e_STABLE_CYCLES, with `step_count` = STABLE_CYCLES.
- Timeout: `timeout` is visible after the edge where `step_count` reaches `max_steps`.
- `busy` falls in the same cycle that `converged` or `timeout` rises.
- Throughput: one step per `valid` cycle, no stalls.

## Test plan
1. **Reset:** assert `reset` for 2 cycles. Then `busy`, `converged`, `timeout`, `step_count`, `max_delta` and `rd_data` (any idx) are all 0.
2. **Convergence:**
   - Stimulus: all nodes 1000, `tol`=0, `max_steps`=0, `start`, then `valid` high for 5 cycles.
   - Required: after the 5th edge `converged`=1, `step_count`=4, `max_delta`=0, `timeout`=0, `rd_data`(idx 2)=1000.
3. **Timeout with downward change:**
   - Stimulus: node0 falls 3000→2990→… by 10 per cycle, others constant, `tol`=5, `max_steps`=8.
   - Required: `timeout`=1 at `step_count`=8, `max_delta`=10, `converged`=0, `rd_data`(0)=2920.
4. **Simultaneous:**
   - Stimulus: constant values, `tol`=0, `max_steps`=4.
   - Required: `converged`=1, `timeout`=0, `step_count`=4.
5. **Valid gaps:**
   - Stimulus: constant values with `valid` toggling 1,0,1,0…
   - Required: `step_count` advances only on valid cycles; converges after 4 valid steps; stable counter survives the gaps.
6. **Abort:**
   - Stimulus: `start` pulsed mid-TRACK at `step_count`=2.
   - Required: `step_count` returns to 0, state is PRIME, `busy`=1.
   - Then `reset` mid-TRACK: all outputs 0 next cycle. `rd_idx`=7 returns 0.
